// File: rtl/cpu_pkg.sv
// Shared CPU constants: control-store geometry, sequencer defaults and the
// bit layout of the sequencing field inside a control word.
package cpu_pkg;
    localparam int AW  = 3;
    localparam int CW  = 21;
    localparam int OPW = 2;

    localparam logic [AW-1:0] FETCH_ADDR = 3'd1;
    localparam logic [AW-1:0] MAP_BASE   = 3'd4;

    // Sequencing field lives in the low bits of the control word
    localparam int SEQ_LSB   = 0;
    localparam int SEQ_MSB   = 2;
    localparam int SEQ_W     = SEQ_MSB - SEQ_LSB + 1;
    localparam int SEQ_MAP   = 2;
    localparam int SEQ_FETCH = 1;
    localparam int SEQ_SKIP  = 0;
endpackage

// File: rtl/useq_next.sv
// Combinational next-address selection for the microsequencer.
// Decides the next micro-PC plus the dispatch handshake/stall flags.
module useq_next #(
    parameter int            AW         = cpu_pkg::AW,
    parameter int            OPW        = cpu_pkg::OPW,
    parameter logic [AW-1:0] FETCH_ADDR = AW'(cpu_pkg::FETCH_ADDR),
    parameter logic [AW-1:0] MAP_BASE   = AW'(cpu_pkg::MAP_BASE)
) (
    input  logic                      reset,
    input  logic                      halt,
    input  logic [cpu_pkg::SEQ_W-1:0] seq,
    input  logic [AW-1:0]             upc,
    input  logic [OPW-1:0]            opcode,
    input  logic                      ir_valid,
    input  logic                      cond,
    output logic [AW-1:0]             addr,
    output logic                      ir_ack,
    output logic                      stall,
    output logic                      fetch_xfer
);
    import cpu_pkg::*;

    // First match wins; FETCH outranks MAP which outranks SKIP
    always_comb begin
        addr       = upc + AW'(1);
        ir_ack     = 1'b0;
        stall      = 1'b0;
        fetch_xfer = 1'b0;
        if (reset) begin
            addr = FETCH_ADDR;
        end else if (halt) begin
            addr = upc;
        end else if (seq[SEQ_FETCH]) begin
            addr       = FETCH_ADDR;
            fetch_xfer = 1'b1;
        end else if (seq[SEQ_MAP]) begin
            if (ir_valid) begin
                addr   = MAP_BASE + AW'(opcode);
                ir_ack = 1'b1;
            end else begin
                addr  = upc;
                stall = 1'b1;
            end
        end else if (seq[SEQ_SKIP]) begin
            addr = cond ? upc + AW'(2) : upc + AW'(1);
        end
    end
endmodule

// File: rtl/useq.sv
// Microprogram sequencer: holds the micro-PC and retired-instruction
// bookkeeping; next-address choice is delegated to useq_next.
module useq #(
    parameter int            AW         = cpu_pkg::AW,
    parameter int            CW         = cpu_pkg::CW,
    parameter int            OPW        = cpu_pkg::OPW,
    parameter logic [AW-1:0] FETCH_ADDR = AW'(cpu_pkg::FETCH_ADDR),
    parameter logic [AW-1:0] MAP_BASE   = AW'(cpu_pkg::MAP_BASE),
    parameter int            CNTW       = 8
) (
    input  logic            clk2,
    input  logic            reset,
    input  logic [CW-1:0]   cword,
    input  logic [OPW-1:0]  opcode,
    input  logic            ir_valid,
    input  logic            cond,
    input  logic            halt,
    output logic [AW-1:0]   addr,
    output logic [AW-1:0]   upc,
    output logic            ir_ack,
    output logic            stall,
    output logic            instr_done,
    output logic [CNTW-1:0] instr_count
);
    import cpu_pkg::*;

    logic [AW-1:0]   upc_q;
    logic            done_q;
    logic [CNTW-1:0] cnt_q;
    logic            fetch_xfer;
    logic [SEQ_W-1:0] seq;
    logic            unused_cword_hi;

    assign seq             = cword[SEQ_MSB:SEQ_LSB];
    assign unused_cword_hi = ^cword[CW-1:SEQ_MSB+1];

    useq_next #(
        .AW         (AW),
        .OPW        (OPW),
        .FETCH_ADDR (FETCH_ADDR),
        .MAP_BASE   (MAP_BASE)
    ) u_next (
        .reset      (reset),
        .halt       (halt),
        .seq        (seq),
        .upc        (upc_q),
        .opcode     (opcode),
        .ir_valid   (ir_valid),
        .cond       (cond),
        .addr       (addr),
        .ir_ack     (ir_ack),
        .stall      (stall),
        .fetch_xfer (fetch_xfer)
    );

    // The control store latches addr on this same edge, keeping cword aligned with upc
    always_ff @(posedge clk2) begin
        if (reset) begin
            upc_q  <= FETCH_ADDR;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            upc_q  <= addr;
            done_q <= fetch_xfer;
            if (fetch_xfer)
                cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign upc         = upc_q;
    assign instr_done  = done_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_useq.sv
// Self-checking bench for useq: per-edge expectations are queued by each
// scenario and popped after the clock edge they describe.
module tb_useq;
    logic        clk2 = 1'b0;
    logic        reset, ir_valid, cond, halt;
    logic [20:0] cword;
    logic [1:0]  opcode;
    logic [2:0]  addr, upc;
    logic        ir_ack, stall, instr_done;
    logic [7:0]  instr_count;

    useq dut (
        .clk2(clk2), .reset(reset), .cword(cword), .opcode(opcode),
        .ir_valid(ir_valid), .cond(cond), .halt(halt), .addr(addr),
        .upc(upc), .ir_ack(ir_ack), .stall(stall),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    always #5 clk2 = ~clk2;

    typedef struct { logic [2:0] upc; logic done; logic [7:0] cnt; } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    logic [2:0] m_upc;
    logic [7:0] m_cnt;

    task automatic expect_next(input logic [2:0] u, input logic d);
        exp_t e;
        e.upc = u; e.done = d; e.cnt = m_cnt;
        sb.push_back(e);
        m_upc = u;
    endtask

    task automatic clk_score(input string nm);
        exp_t e;
        @(posedge clk2); #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            n_cmp++; if (upc !== e.upc) begin n_bad++; $display("FAIL %s upc: got %0d want %0d", nm, upc, e.upc); end
            n_cmp++; if (instr_done !== e.done) begin n_bad++; $display("FAIL %s instr_done: got %b want %b", nm, instr_done, e.done); end
            n_cmp++; if (instr_count !== e.cnt) begin n_bad++; $display("FAIL %s instr_count: got %0d want %0d", nm, instr_count, e.cnt); end
        end
    endtask

    task automatic walk(input logic [2:0] to);
        reset = 0; halt = 0; cond = 0; ir_valid = 0; cword = '0;
        repeat (8) begin
            if (m_upc != to) begin
                expect_next(m_upc + 3'd1, 1'b0);
                clk_score("walk");
            end
        end
    endtask

    task automatic test_reset;
        reset = 1; cword = '0; opcode = 0; ir_valid = 0; cond = 0; halt = 0;
        m_cnt = 0;
        #1;
        n_cmp++; if (addr !== 3'd1) begin n_bad++; $display("FAIL reset_addr: got %0d want 1", addr); end
        n_cmp++; if (ir_ack !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL reset_ack_stall: got %b%b want 00", ir_ack, stall); end
        expect_next(3'd1, 1'b0); clk_score("reset1");
        expect_next(3'd1, 1'b0); clk_score("reset2");
        reset = 0;
        expect_next(3'd2, 1'b0); clk_score("next_a");
        expect_next(3'd3, 1'b0); clk_score("next_b");
    endtask

    task automatic test_map;
        cword = {18'h2AAAA, 3'b100}; opcode = 2'd2; ir_valid = 1; #1;
        n_cmp++; if (addr !== 3'd6) begin n_bad++; $display("FAIL map_addr: got %0d want 6", addr); end
        n_cmp++; if (ir_ack !== 1'b1) begin n_bad++; $display("FAIL map_ack: got %b want 1", ir_ack); end
        expect_next(3'd6, 1'b0); clk_score("map");
        walk(3'd3);
        cword = 21'b100; ir_valid = 0;
        repeat (3) begin
            #1;
            n_cmp++; if (stall !== 1'b1 || ir_ack !== 1'b0) begin n_bad++; $display("FAIL map_stall: got stall=%b ack=%b want 1/0", stall, ir_ack); end
            n_cmp++; if (addr !== 3'd3) begin n_bad++; $display("FAIL stall_addr: got %0d want 3", addr); end
            expect_next(3'd3, 1'b0); clk_score("stall");
        end
        ir_valid = 1; #1;
        n_cmp++; if (ir_ack !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL stall_release: got ack=%b stall=%b want 1/0", ir_ack, stall); end
        expect_next(3'd6, 1'b0); clk_score("map_resume");
    endtask

    task automatic test_skip;
        walk(3'd5);
        cword = 21'b001; cond = 1;
        expect_next(3'd7, 1'b0); clk_score("skip_taken");
        expect_next(3'd1, 1'b0); clk_score("skip_wrap");
        walk(3'd7);
        cword = 21'b001; cond = 0; #1;
        n_cmp++; if (addr !== 3'd0) begin n_bad++; $display("FAIL skip_not_taken_addr: got %0d want 0", addr); end
        expect_next(3'd0, 1'b0); clk_score("skip_not_taken");
    endtask

    task automatic test_fetch;
        walk(3'd5);
        for (int i = 0; i < 3; i++) begin
            cword = (i == 2) ? {18'h15555, 3'b111} : 21'b010;
            ir_valid = 1; opcode = 2'd3; #1;
            n_cmp++; if (addr !== 3'd1 || ir_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_prio: got addr=%0d ack=%b want 1/0", addr, ir_ack); end
            m_cnt++;
            expect_next(3'd1, 1'b1); clk_score("fetch");
            if (i < 2) walk(3'd5);
        end
        cword = 21'b010;
        repeat (253) begin
            m_cnt++;
            expect_next(3'd1, 1'b1); clk_score("fetch_wrap");
        end
        n_cmp++; if (instr_count !== 8'd0) begin n_bad++; $display("FAIL count_wrap: got %0d want 0", instr_count); end
    endtask

    task automatic test_halt;
        halt = 1; cword = 21'b010; #1;
        n_cmp++; if (addr !== 3'd1 || ir_ack !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL halt_fetch_comb: got addr=%0d ack=%b stall=%b want 1/0/0", addr, ir_ack, stall); end
        expect_next(3'd1, 1'b0); clk_score("halt_fetch1");
        expect_next(3'd1, 1'b0); clk_score("halt_fetch2");
        halt = 0; m_cnt++;
        expect_next(3'd1, 1'b1); clk_score("halt_release_fetch");
        walk(3'd3);
        cword = 21'b100; opcode = 2'd2; ir_valid = 1; halt = 1; #1;
        n_cmp++; if (ir_ack !== 1'b0 || addr !== 3'd3) begin n_bad++; $display("FAIL halt_map: got ack=%b addr=%0d want 0/3", ir_ack, addr); end
        expect_next(3'd3, 1'b0); clk_score("halt_map");
        halt = 0; #1;
        n_cmp++; if (ir_ack !== 1'b1 || addr !== 3'd6) begin n_bad++; $display("FAIL halt_map_resume: got ack=%b addr=%0d want 1/6", ir_ack, addr); end
        expect_next(3'd6, 1'b0); clk_score("halt_map_resume");
    endtask

    task automatic test_reset_stall;
        walk(3'd3);
        cword = 21'b100; ir_valid = 0; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL pre_reset_stall: got %b want 1", stall); end
        expect_next(3'd3, 1'b0); clk_score("stalled");
        reset = 1; ir_valid = 1; #1;
        n_cmp++; if (stall !== 1'b0 || ir_ack !== 1'b0 || addr !== 3'd1) begin n_bad++; $display("FAIL reset_stall_comb: got stall=%b ack=%b addr=%0d want 0/0/1", stall, ir_ack, addr); end
        m_cnt = 0;
        expect_next(3'd1, 1'b0); clk_score("reset_from_stall");
        reset = 0; ir_valid = 0; cword = '0;
        expect_next(3'd2, 1'b0); clk_score("after_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_map;
        test_skip;
        test_fetch;
        test_halt;
        test_reset_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/useq.md
Name: useq

Overview:
- Microprogram sequencer. It generates the 3-bit control-store address each clk2 cycle and consumes the 21-bit control word returned by the control-store register.
- Next address is computed from the sequencing field of the current control word, the instruction opcode (dispatch), a condition flag (skip) and a halt request.
- It sits between the instruction register/flag logic and the control store. It closes the microcode loop so that exactly one microinstruction executes per clk2 cycle.

Parameters:
- AW, 3, control-store address width.
- CW, 21, control word width.
- OPW, 2, opcode width used for dispatch.
- FETCH_ADDR, 1, address of the fetch microinstruction; also the reset address.
- MAP_BASE, 4, dispatch base; dispatch target = MAP_BASE + opcode, modulo 2^AW.
- CNTW, 8, width of the retired-instruction counter.

Ports:
- clk2  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cword  in  CW  current control word; always equals store[upc].
- opcode  in  OPW  instruction opcode for dispatch.
- ir_valid  in  1  opcode valid.
- cond  in  1  condition flag for conditional skip.
- halt  in  1  freeze sequencing.
- addr  out  AW  next control-store address (combinational); the store latches it on the same edge that upc does.
- upc  out  AW  registered micro-PC of the executing microinstruction.
- ir_ack  out  1  opcode consumed this cycle (combinational).
- stall  out  1  dispatch waiting on ir_valid (combinational).
- instr_done  out  1  registered pulse, 1 cycle after a FETCH transfer.
- instr_count  out  CNTW  number of FETCH transfers since reset.

Behaviour:
- Sequence field is seq = cword[2:0]:
  - bit2 = MAP
  - bit1 = FETCH
  - bit0 = SKIP
- Priority when several bits are set: FETCH > MAP > SKIP. 000 = NEXT.
- Next-address selection (combinational, first match wins):
  - reset: addr = FETCH_ADDR.
  - halt: addr = upc (hold). ir_ack = 0, stall = 0.
  - FETCH: addr = FETCH_ADDR.
  - MAP with ir_valid=1: addr = MAP_BASE+opcode, ir_ack = 1.
  - MAP with ir_valid=0: addr = upc, stall = 1, ir_ack = 0.
  - SKIP: addr = upc+2 if cond, else upc+1.
  - NEXT: addr = upc+1.
- All address arithmetic is AW bits and wraps modulo 2^AW (7+1 → 0, 6+2 → 0, 7+2 → 1).
- Register update on posedge clk2: upc ← addr. Because the store latches addr on the same edge, cword stays aligned with upc (zero bubble, one microinstruction per cycle).
- ir_ack is asserted only in the MAP-with-valid case; the handshake completes in the cycle where ir_valid && ir_ack. Opcode must be stable while ir_valid=1 and unacknowledged.
- Transfer counting: a FETCH transfer is a cycle with FETCH selected, no halt, no reset. That cycle sets instr_done=1 for the next cycle and increments instr_count, which wraps at 2^CNTW.
- Reset:
  - upc = FETCH_ADDR, instr_done = 0, instr_count = 0.
  - ir_ack = 0 and stall = 0 while reset is high.
  - Reset during stall or halt abandons the pending dispatch; ir_valid stays unacknowledged.
- Halt:
  - halt together with a pending MAP: no ack; dispatch resumes when halt drops.
  - halt overrides FETCH: no count, no instr_done.
- cword bits [CW-1:3] are ignored by this block.

Decomposition:
- Shared package (cpu_pkg) holds:
  - AW, CW, OPW, FETCH_ADDR, MAP_BASE.
  - Seq-field bit positions: SEQ_MAP=2, SEQ_FETCH=1, SEQ_SKIP=0.
  - The seq-field slice range.
- One natural sub-module, useq_next: purely combinational next-address/ack/stall selection. useq holds the registers and counters.

Test Plan:
- Reset held 2 cycles with cword=0 → addr=1, upc=1, instr_count=0, ir_ack=0. Release with seq=000 → upc 1→2→3.
- MAP at upc=3, opcode=2, ir_valid=1 → addr=6, ir_ack=1, next upc=6. Repeat with ir_valid=0 for 3 cycles → stall=1, upc=3 held, then raise ir_valid → upc=6.
- SKIP at upc=5: cond=1 → upc=7; at upc=7 with cond=1 → upc=1 (wrap); cond=0 at upc=7 → upc=0.
- seq=010 at upc=5 twice, then seq=111 once → each transfer gives upc=1, instr_done pulse, instr_count=3 (FETCH wins over MAP). With CNTW=8, 256 fetches → count wraps to 0.
- halt=1 during seq=010 and during a pending MAP → upc frozen, no ack, count unchanged; release → resumes correctly.
- Reset asserted while stalled on MAP (upc=3) → next cycle upc=1, stall=0, ir_ack=0, counters 0.
